// File: rtl/usb_ep0_if.sv
// Signals between the usb transaction core, the descriptor ROM and the EP0 sequencer.
// The master modport is the core/ROM side; the slave modport is the EP0 sequencer.
interface usb_ep0_if;
  logic       transaction_active;
  logic [3:0] endpoint;
  logic       direction_in;
  logic       setup;
  logic       data_strobe;
  logic [7:0] data_out;
  logic       success;
  logic [1:0] handshake;
  logic       data_toggle;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic [4:0] desc_addr;
  logic [7:0] desc_data;
  logic [6:0] usb_address;
  logic       configured;

  modport master (
    output transaction_active, endpoint, direction_in, setup, data_strobe,
           data_out, success, desc_data,
    input  handshake, data_toggle, data_in, data_in_valid, desc_addr,
           usb_address, configured
  );

  modport slave (
    input  transaction_active, endpoint, direction_in, setup, data_strobe,
           data_out, success, desc_data,
    output handshake, data_toggle, data_in, data_in_valid, desc_addr,
           usb_address, configured
  );
endinterface

// File: rtl/usb_ep0_ctrl.sv
// EP0 control sequencer: captures SETUP packets, serves the device descriptor from ROM,
// and runs the status stages for SET_ADDRESS / SET_CONFIGURATION.
module usb_ep0_ctrl #(
  parameter int DESC_LEN = 18,
  parameter int MAX_PKT  = 8
) (
  input  logic      clk48mhz,
  input  logic      rst,
  input  logic      usb_rst,
  usb_ep0_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA_IN, S_STATUS_OUT, S_STATUS_IN, S_STALL
  } state_t;

  localparam logic [1:0]  HS_ACK     = 2'b00;
  localparam logic [1:0]  HS_NONE    = 2'b01;
  localparam logic [1:0]  HS_NAK     = 2'b10;
  localparam logic [1:0]  HS_STALL   = 2'b11;
  localparam logic [15:0] MAX_PKT_H  = 16'(MAX_PKT);
  localparam logic [15:0] DESC_LEN_H = 16'(DESC_LEN);

  function automatic logic [15:0] sat_min(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t     state;
  logic       active_q;
  logic       strobe_q;
  logic       succ_seen;
  logic [3:0] cnt;
  logic [7:0] setup_buf [8];
  logic [7:0] len;
  logic [7:0] offset;
  logic [7:0] idx;
  logic       toggle;
  logic [6:0] pending_addr;
  logic       addr_pending;
  logic [6:0] address_r;
  logic       configured_r;
  logic [4:0] desc_addr_r;
  logic [7:0] data_in_r;
  logic       data_in_valid_r;
  logic       vld_p0;
  logic       vld_p1;
  logic [1:0] hs;

  logic        strb_rise, start, fin, ep0;
  logic [7:0]  remain, pkt, len_next;
  logic [15:0] wlength;
  logic        req_get_dev, req_set_addr, req_set_cfg;

  assign strb_rise = bus.data_strobe & ~strobe_q;
  assign start     = bus.transaction_active & ~active_q;
  assign fin       = ~bus.transaction_active & active_q;
  assign ep0       = (bus.endpoint == 4'd0);

  assign remain   = len - offset;
  assign pkt      = 8'(sat_min({8'd0, remain}, MAX_PKT_H));
  assign wlength  = {setup_buf[7], setup_buf[6]};
  assign len_next = 8'(sat_min(wlength, DESC_LEN_H));

  assign req_get_dev  = (setup_buf[0] == 8'h80) && (setup_buf[1] == 8'h06) &&
                        (setup_buf[3] == 8'h01);
  assign req_set_addr = (setup_buf[0] == 8'h00) && (setup_buf[1] == 8'h05);
  assign req_set_cfg  = (setup_buf[0] == 8'h00) && (setup_buf[1] == 8'h09);

  always_comb begin
    hs = HS_NONE;
    if (!ep0)
      hs = HS_STALL;
    else if (bus.setup)
      hs = HS_ACK;
    else begin
      case (state)
        S_IDLE:       hs = HS_NAK;
        S_DATA_IN:    hs = HS_ACK;
        S_STATUS_OUT: hs = bus.direction_in ? HS_NAK : HS_ACK;
        S_STATUS_IN:  hs = bus.direction_in ? HS_ACK : HS_NAK;
        S_STALL:      hs = HS_STALL;
        default:      hs = HS_NONE;
      endcase
    end
  end

  assign bus.handshake     = hs;
  assign bus.data_toggle   = toggle;
  assign bus.data_in       = data_in_r;
  assign bus.data_in_valid = data_in_valid_r;
  assign bus.desc_addr     = desc_addr_r;
  assign bus.usb_address   = address_r;
  assign bus.configured    = configured_r;

  always_ff @(posedge clk48mhz) begin
    if (rst || usb_rst) begin
      state           <= S_IDLE;
      active_q        <= 1'b0;
      strobe_q        <= 1'b0;
      succ_seen       <= 1'b0;
      cnt             <= 4'd0;
      len             <= 8'd0;
      offset          <= 8'd0;
      idx             <= 8'd0;
      toggle          <= 1'b0;
      pending_addr    <= 7'd0;
      addr_pending    <= 1'b0;
      address_r       <= 7'd0;
      configured_r    <= 1'b0;
      desc_addr_r     <= 5'd0;
      data_in_r       <= 8'd0;
      data_in_valid_r <= 1'b0;
      vld_p0          <= 1'b0;
      vld_p1          <= 1'b0;
    end else begin
      active_q <= bus.transaction_active;
      strobe_q <= bus.data_strobe;
      vld_p0   <= 1'b0;
      // p0 -> p1: ROM registers the new address; p1 -> out: byte lands in data_in
      vld_p1   <= vld_p0;
      if (vld_p1 && state == S_DATA_IN) begin
        data_in_r       <= bus.desc_data;
        data_in_valid_r <= (idx < pkt);
      end

      if (ep0 && bus.setup) begin
        if (start)
          cnt <= 4'd0;
        if (strb_rise && cnt < 4'd8) begin
          setup_buf[cnt[2:0]] <= bus.data_out;
          cnt                 <= cnt + 4'd1;
        end
        if (bus.success && cnt == 4'd8) begin
          data_in_valid_r <= 1'b0;
          vld_p1          <= 1'b0;
          idx             <= 8'd0;
          if (req_get_dev) begin
            len    <= len_next;
            offset <= 8'd0;
            toggle <= 1'b1;
            state  <= S_DATA_IN;
          end else if (req_set_addr) begin
            pending_addr <= setup_buf[2][6:0];
            addr_pending <= 1'b1;
            toggle       <= 1'b1;
            state        <= S_STATUS_IN;
          end else if (req_set_cfg) begin
            configured_r <= (setup_buf[2] != 8'd0);
            toggle       <= 1'b1;
            state        <= S_STATUS_IN;
          end else begin
            state <= S_STALL;
          end
        end
      end else if (ep0 && state == S_DATA_IN && bus.direction_in) begin
        if (start) begin
          desc_addr_r <= offset[4:0];
          idx         <= 8'd0;
          vld_p0      <= 1'b1;
          succ_seen   <= 1'b0;
        end
        if (strb_rise && idx < pkt) begin
          idx         <= idx + 8'd1;
          desc_addr_r <= desc_addr_r + 5'd1;
          vld_p0      <= 1'b1;
          if (idx + 8'd1 >= pkt)
            data_in_valid_r <= 1'b0;
        end
        if (bus.success) begin
          succ_seen       <= 1'b1;
          offset          <= offset + pkt;
          toggle          <= ~toggle;
          data_in_valid_r <= 1'b0;
          if (offset + pkt == len)
            state <= S_STATUS_OUT;
        end
        // Packet lost: rewind so the next IN resends the same bytes with the same toggle
        if (fin && !succ_seen && !bus.success) begin
          idx             <= 8'd0;
          desc_addr_r     <= offset[4:0];
          data_in_valid_r <= 1'b0;
        end
      end else if (ep0 && bus.success) begin
        case (state)
          S_DATA_IN:    state <= S_IDLE;
          S_STATUS_OUT: if (!bus.direction_in) state <= S_IDLE;
          S_STATUS_IN: begin
            if (bus.direction_in) begin
              if (addr_pending)
                address_r <= pending_addr;
              addr_pending <= 1'b0;
              state        <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_ep0_ctrl.sv
// Directed bench for usb_ep0_ctrl: emulates the usb core and descriptor ROM, and checks
// IN packet contents against a scoreboard of expected ROM bytes.
module tb_usb_ep0_ctrl;

  localparam logic [1:0] ACK   = 2'b00;
  localparam logic [1:0] NAK   = 2'b10;
  localparam logic [1:0] STALL = 2'b11;

  logic clk48mhz = 1'b0;
  logic rst      = 1'b1;
  logic usb_rst  = 1'b0;

  usb_ep0_if bus ();

  usb_ep0_ctrl #(.DESC_LEN(18), .MAX_PKT(8)) dut (
    .clk48mhz (clk48mhz),
    .rst      (rst),
    .usb_rst  (usb_rst),
    .bus      (bus)
  );

  always #10 clk48mhz = ~clk48mhz;

  logic [7:0] rom [32];
  always @(posedge clk48mhz) bus.desc_data <= rom[bus.desc_addr];

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  task automatic tick();
    @(posedge clk48mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic send_setup(input logic [63:0] pkt);
    bus.endpoint           = 4'd0;
    bus.direction_in       = 1'b0;
    bus.setup              = 1'b1;
    bus.transaction_active = 1'b1;
    tick();
    check("setup_hs", bus.handshake, ACK);
    for (int i = 0; i < 8; i++) begin
      bus.data_out    = pkt[8*i +: 8];
      bus.data_strobe = 1'b1;
      tick();
      bus.data_strobe = 1'b0;
      tick();
    end
    bus.success = 1'b1;
    tick();
    bus.success            = 1'b0;
    bus.transaction_active = 1'b0;
    bus.setup              = 1'b0;
    tick();
  endtask

  // One IN data packet on EP0; expected bytes are queued from the ROM model up front.
  task automatic in_xfer(input int exp_len, input logic exp_tog, input bit ok, input int off);
    int n;
    logic [7:0] e;
    for (int i = 0; i < exp_len; i++) exp_q.push_back(rom[off + i]);
    bus.endpoint           = 4'd0;
    bus.direction_in       = 1'b1;
    bus.setup              = 1'b0;
    bus.transaction_active = 1'b1;
    repeat (4) tick();
    check("in_hs", bus.handshake, ACK);
    check("in_toggle", bus.data_toggle, exp_tog);
    n = 0;
    for (int g = 0; g < 12 && bus.data_in_valid; g++) begin
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      check("in_byte", bus.data_in, e);
      n++;
      bus.data_strobe = 1'b1;
      tick();
      bus.data_strobe = 1'b0;
      repeat (3) tick();
    end
    check("in_pkt_len", n, exp_len);
    while (exp_q.size() != 0) void'(exp_q.pop_front());
    if (ok) begin
      bus.success = 1'b1;
      tick();
      bus.success = 1'b0;
    end
    bus.transaction_active = 1'b0;
    repeat (2) tick();
  endtask

  task automatic txn(input logic dir, input logic [3:0] ep, input logic [1:0] exp_hs,
                     input bit ok, input string tag);
    bus.endpoint           = ep;
    bus.direction_in       = dir;
    bus.setup              = 1'b0;
    bus.transaction_active = 1'b1;
    repeat (2) tick();
    check(tag, bus.handshake, exp_hs);
    if (ok) begin
      bus.success = 1'b1;
      tick();
      bus.success = 1'b0;
    end
    bus.transaction_active = 1'b0;
    bus.endpoint           = 4'd0;
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'((i * 37 + 5) & 255);
    rom[0] = 8'h12;
    rom[1] = 8'h01;
    rom[7] = 8'h08;
    bus.transaction_active = 1'b0;
    bus.endpoint           = 4'd0;
    bus.direction_in       = 1'b0;
    bus.setup              = 1'b0;
    bus.data_strobe        = 1'b0;
    bus.data_out           = 8'd0;
    bus.success            = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_addr", bus.usb_address, 7'd0);
    check("rst_cfg", bus.configured, 1'b0);
    check("rst_valid", bus.data_in_valid, 1'b0);
    check("rst_toggle", bus.data_toggle, 1'b0);
    check("rst_data_in", bus.data_in, 8'd0);
    check("rst_desc_addr", bus.desc_addr, 5'd0);
    check("rst_hs_ep0", bus.handshake, NAK);
    bus.endpoint = 4'd2;
    #1;
    check("rst_hs_ep2", bus.handshake, STALL);
    bus.endpoint = 4'd0;
    rst = 1'b0;
    tick();

    // GET_DESCRIPTOR(device), wLength=0x40: 8 + 8 + 2 bytes
    send_setup(mk(8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00));
    in_xfer(8, 1'b1, 1'b1, 0);
    in_xfer(8, 1'b0, 1'b1, 8);
    in_xfer(2, 1'b1, 1'b1, 16);
    txn(1'b1, 4'd0, NAK, 1'b0, "stat_out_in_nak");
    txn(1'b0, 4'd0, ACK, 1'b1, "stat_out_ack");
    txn(1'b0, 4'd0, NAK, 1'b0, "idle_out_nak");

    // GET_DESCRIPTOR, wLength=8
    send_setup(mk(8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h08, 8'h00));
    txn(1'b1, 4'd2, STALL, 1'b0, "ep2_in_stall");
    in_xfer(8, 1'b1, 1'b1, 0);
    txn(1'b1, 4'd0, NAK, 1'b0, "len8_in_nak");
    txn(1'b0, 4'd0, ACK, 1'b1, "len8_out_ack");

    // SET_ADDRESS 5: address moves only on status success
    send_setup(mk(8'h00, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    check("addr_after_setup", bus.usb_address, 7'd0);
    txn(1'b0, 4'd0, NAK, 1'b0, "stat_in_out_nak");
    bus.direction_in       = 1'b1;
    bus.transaction_active = 1'b1;
    repeat (2) tick();
    check("zlp_hs", bus.handshake, ACK);
    check("zlp_valid", bus.data_in_valid, 1'b0);
    check("zlp_toggle", bus.data_toggle, 1'b1);
    check("addr_before_ok", bus.usb_address, 7'd0);
    bus.success = 1'b1;
    tick();
    check("addr_after_ok", bus.usb_address, 7'd5);
    bus.success            = 1'b0;
    bus.transaction_active = 1'b0;
    repeat (2) tick();
    txn(1'b0, 4'd0, NAK, 1'b0, "addr_idle_nak");

    // SET_CONFIGURATION 1
    send_setup(mk(8'h00, 8'h09, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    txn(1'b1, 4'd0, ACK, 1'b1, "cfg_zlp_ack");
    check("cfg_set", bus.configured, 1'b1);

    // IN retry, then usb_rst in the middle of a DATA_IN packet
    send_setup(mk(8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00));
    in_xfer(8, 1'b1, 1'b0, 0);
    in_xfer(8, 1'b1, 1'b1, 0);
    bus.direction_in       = 1'b1;
    bus.transaction_active = 1'b1;
    repeat (4) tick();
    check("mid_valid", bus.data_in_valid, 1'b1);
    check("mid_toggle", bus.data_toggle, 1'b0);
    usb_rst = 1'b1;
    tick();
    usb_rst = 1'b0;
    check("urst_addr", bus.usb_address, 7'd0);
    check("urst_cfg", bus.configured, 1'b0);
    check("urst_valid", bus.data_in_valid, 1'b0);
    check("urst_toggle", bus.data_toggle, 1'b0);
    bus.transaction_active = 1'b0;
    repeat (2) tick();
    txn(1'b0, 4'd0, NAK, 1'b0, "urst_idle_nak");

    // Unknown request stalls until the next SETUP
    send_setup(mk(8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    txn(1'b1, 4'd0, STALL, 1'b0, "unk_in_stall");
    txn(1'b0, 4'd0, STALL, 1'b0, "unk_out_stall");
    send_setup(mk(8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h08, 8'h00));
    in_xfer(8, 1'b1, 1'b1, 0);
    txn(1'b0, 4'd0, ACK, 1'b1, "after_stall_ack");

    // Other descriptor type stalls
    send_setup(mk(8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, 8'h09, 8'h00));
    txn(1'b1, 4'd0, STALL, 1'b0, "cfgdesc_stall");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
